// File: rtl/register_general_pkg.sv
// Shared types and helpers for the x86 general-purpose register file:
// operand sizes, architectural register numbers and sized merge/extract rules.
package register_general_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_WORD    = 2'b01,
        SZ_DWORD   = 2'b10,
        SZ_ILLEGAL = 2'b11
    } operand_size_t;

    localparam int unsigned REG_EAX = 0;
    localparam int unsigned REG_ECX = 1;
    localparam int unsigned REG_EDX = 2;
    localparam int unsigned REG_EBX = 3;
    localparam int unsigned REG_ESP = 4;
    localparam int unsigned REG_EBP = 5;
    localparam int unsigned REG_ESI = 6;
    localparam int unsigned REG_EDI = 7;

    // Byte operands 4..7 name AH/CH/DH/BH, which live in registers 0..3.
    function automatic int unsigned byte_lane_map(input int unsigned index,
                                                  input operand_size_t size);
        if (size == SZ_BYTE && index >= 4 && index <= 7) begin
            return index - 4;
        end
        return index;
    endfunction

    function automatic logic is_high_byte(input int unsigned index,
                                          input operand_size_t size);
        return (size == SZ_BYTE && index >= 4 && index <= 7);
    endfunction

    function automatic logic [31:0] size_merge(input logic [31:0] current,
                                               input logic [31:0] data,
                                               input operand_size_t size,
                                               input logic high_byte);
        logic [31:0] merged;
        merged = current;
        case (size)
            SZ_BYTE: begin
                if (high_byte) merged[15:8] = data[7:0];
                else merged[7:0] = data[7:0];
            end
            SZ_WORD:  merged[15:0] = data[15:0];
            SZ_DWORD: merged = data;
            default:  merged = current;
        endcase
        return merged;
    endfunction

    function automatic logic [31:0] size_extract(input logic [31:0] value,
                                                 input operand_size_t size,
                                                 input logic high_byte);
        logic [31:0] result;
        result = '0;
        case (size)
            SZ_BYTE: begin
                if (high_byte) result[7:0] = value[15:8];
                else result[7:0] = value[7:0];
            end
            SZ_WORD:  result[15:0] = value[15:0];
            SZ_DWORD: result = value;
            default:  result = '0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/register_general_read_port.sv
// One sized read port: maps the operand index to a physical register, forwards
// an in-flight write when enabled, extracts the sized value and looks up busy.
module register_general_read_port
    import register_general_pkg::*;
#(
    parameter int REG_COUNT = 8,
    parameter int IW        = 3
)(
    input  logic [IW-1:0]          index,
    input  operand_size_t          size,
    input  logic [REG_COUNT*32-1:0] regs_flat,
    input  logic [REG_COUNT-1:0]   busy,
    input  logic                   fwd_enable,
    input  logic [IW-1:0]          fwd_index,
    input  logic [31:0]            fwd_value,
    output logic [31:0]            data,
    output logic                   read_busy
);

    logic [IW-1:0] phys;
    logic          high;
    logic [31:0]   value;

    always_comb begin
        phys  = IW'(byte_lane_map(32'(index), size));
        high  = is_high_byte(32'(index), size);
        value = regs_flat[32*phys +: 32];
        // The forwarded value is the whole merged register, so any read size works.
        if (fwd_enable && fwd_index == phys) begin
            value = fwd_value;
        end
        data      = size_extract(value, size, high);
        read_busy = busy[phys];
    end

endmodule

// File: rtl/register_general_file.sv
// x86 GPR file with sized merging writes, sized read ports, optional write
// bypass, an ESP push/pop adjuster and a per-register busy scoreboard.
module register_general_file
    import register_general_pkg::*;
#(
    parameter int REG_COUNT  = 8,
    parameter int READ_PORTS = 2,
    parameter bit BYPASS     = 1'b1,
    localparam int IW        = $clog2(REG_COUNT)
)(
    input  logic                             clock,
    input  logic                             reset,
    input  logic [READ_PORTS-1:0][IW-1:0]    read_index,
    input  logic [READ_PORTS-1:0][1:0]       read_size,
    output logic [READ_PORTS-1:0][31:0]      read_data,
    output logic [READ_PORTS-1:0]            read_busy,
    input  logic                             write_enable,
    input  logic [IW-1:0]                    write_index,
    input  logic [1:0]                       write_size,
    input  logic [31:0]                      write_data,
    input  logic                             stack_enable,
    input  logic                             stack_pop,
    input  logic                             stack_op32,
    input  logic                             stack_addr32,
    input  logic                             issue_enable,
    input  logic [IW-1:0]                    issue_index,
    output logic [REG_COUNT-1:0]             busy,
    output logic [REG_COUNT*32-1:0]          regs_flat,
    output logic                             size_error
);

    logic [31:0]          regs [REG_COUNT];
    operand_size_t        w_size;
    logic                 w_legal;
    logic                 w_high;
    logic                 w_commit;
    logic [IW-1:0]        w_phys;
    logic [31:0]          w_merged;
    logic                 stack_commit;
    logic [31:0]          esp;
    logic [31:0]          delta;
    logic [31:0]          esp_next;
    logic [REG_COUNT-1:0] busy_next;
    logic                 size_error_next;

    always_comb begin
        w_size   = operand_size_t'(write_size);
        w_legal  = (w_size != SZ_ILLEGAL);
        w_phys   = IW'(byte_lane_map(32'(write_index), w_size));
        w_high   = is_high_byte(32'(write_index), w_size);
        w_merged = size_merge(regs[w_phys], write_data, w_size, w_high);
        w_commit = write_enable && w_legal;

        // An explicit write to ESP wins over a same-cycle push/pop.
        stack_commit = stack_enable && !(w_commit && w_phys == IW'(REG_ESP));
        esp   = regs[REG_ESP];
        delta = stack_op32 ? 32'd4 : 32'd2;
        if (stack_addr32) begin
            esp_next = stack_pop ? esp + delta : esp - delta;
        end else begin
            esp_next = {esp[31:16], stack_pop ? esp[15:0] + delta[15:0]
                                              : esp[15:0] - delta[15:0]};
        end

        // Clear then set, so issue and writeback of one register leave it busy.
        busy_next = busy;
        if (w_commit) busy_next[w_phys] = 1'b0;
        if (issue_enable) busy_next[issue_index] = 1'b1;

        size_error_next = write_enable && !w_legal;
        for (int p = 0; p < READ_PORTS; p++) begin
            if (read_size[p] == 2'b11) size_error_next = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
            busy       <= '0;
            size_error <= 1'b0;
        end else begin
            if (w_commit) regs[w_phys] <= w_merged;
            if (stack_commit) regs[REG_ESP] <= esp_next;
            busy       <= busy_next;
            size_error <= size_error_next;
        end
    end

    for (genvar i = 0; i < REG_COUNT; i++) begin : g_flat
        assign regs_flat[32*i +: 32] = regs[i];
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
        register_general_read_port #(
            .REG_COUNT(REG_COUNT),
            .IW       (IW)
        ) u_port (
            .index     (read_index[p]),
            .size      (operand_size_t'(read_size[p])),
            .regs_flat (regs_flat),
            .busy      (busy),
            .fwd_enable(BYPASS && w_commit),
            .fwd_index (w_phys),
            .fwd_value (w_merged),
            .data      (read_data[p]),
            .read_busy (read_busy[p])
        );
    end

endmodule

// File: tb/tb_register_general_file.sv
// Bench for register_general_file: directed scenarios plus randomized traffic
// checked against an architectural model of the x86 register file.
module tb_register_general_file;

    localparam int REG_COUNT  = 8;
    localparam int READ_PORTS = 2;
    localparam int IW         = 3;

    logic                          clock = 1'b0;
    logic                          reset;
    logic [READ_PORTS-1:0][IW-1:0] read_index;
    logic [READ_PORTS-1:0][1:0]    read_size;
    logic [READ_PORTS-1:0][31:0]   read_data;
    logic [READ_PORTS-1:0]         read_busy;
    logic                          write_enable;
    logic [IW-1:0]                 write_index;
    logic [1:0]                    write_size;
    logic [31:0]                   write_data;
    logic                          stack_enable;
    logic                          stack_pop;
    logic                          stack_op32;
    logic                          stack_addr32;
    logic                          issue_enable;
    logic [IW-1:0]                 issue_index;
    logic [REG_COUNT-1:0]          busy;
    logic [REG_COUNT*32-1:0]       regs_flat;
    logic                          size_error;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] m_regs [REG_COUNT];
    logic [REG_COUNT-1:0] m_busy;
    logic m_size_err;

    register_general_file #(
        .REG_COUNT (REG_COUNT),
        .READ_PORTS(READ_PORTS),
        .BYPASS    (1'b1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .read_index  (read_index),
        .read_size   (read_size),
        .read_data   (read_data),
        .read_busy   (read_busy),
        .write_enable(write_enable),
        .write_index (write_index),
        .write_size  (write_size),
        .write_data  (write_data),
        .stack_enable(stack_enable),
        .stack_pop   (stack_pop),
        .stack_op32  (stack_op32),
        .stack_addr32(stack_addr32),
        .issue_enable(issue_enable),
        .issue_index (issue_index),
        .busy        (busy),
        .regs_flat   (regs_flat),
        .size_error  (size_error)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Byte names 4..7 are AH..BH: bits 15:8 of registers 0..3.
    function automatic int m_target(int idx, logic [1:0] sz);
        if (sz == 2'b00 && idx >= 4 && idx <= 7) return idx - 4;
        return idx;
    endfunction

    function automatic void model_write(int idx, logic [1:0] sz, logic [31:0] d);
        int t;
        t = m_target(idx, sz);
        case (sz)
            2'b10: m_regs[t] = d;
            2'b01: m_regs[t] = (m_regs[t] & 32'hFFFF_0000) | (d & 32'h0000_FFFF);
            2'b00: begin
                if (t != idx) m_regs[t] = (m_regs[t] & ~32'h0000_FF00) | ((d & 32'hFF) << 8);
                else m_regs[t] = (m_regs[t] & ~32'h0000_00FF) | (d & 32'hFF);
            end
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] model_read(int idx, logic [1:0] sz);
        logic [31:0] v;
        int t;
        t = m_target(idx, sz);
        v = m_regs[t];
        case (sz)
            2'b10:   return v;
            2'b01:   return v & 32'h0000_FFFF;
            2'b00:   return (t != idx) ? ((v >> 8) & 32'hFF) : (v & 32'hFF);
            default: return 32'h0;
        endcase
    endfunction

    // Value a read port must show this cycle, with the pending write forwarded.
    function automatic logic [31:0] fwd_read(int idx, logic [1:0] sz);
        logic [31:0] saved [REG_COUNT];
        logic [31:0] r;
        saved = m_regs;
        if (write_enable && write_size != 2'b11) model_write(int'(write_index), write_size, write_data);
        r = model_read(idx, sz);
        m_regs = saved;
        return r;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < REG_COUNT; i++) m_regs[i] = 32'h0;
        m_busy     = '0;
        m_size_err = 1'b0;
    endfunction

    function automatic void model_apply();
        logic        legal;
        int          t;
        logic [31:0] d;
        logic [31:0] e;
        legal = write_enable && write_size != 2'b11;
        t     = m_target(int'(write_index), write_size);
        m_size_err = (write_enable && write_size == 2'b11) ||
                     read_size[0] == 2'b11 || read_size[1] == 2'b11;
        if (stack_enable && !(legal && t == 4)) begin
            d = stack_op32 ? 32'd4 : 32'd2;
            e = stack_pop ? m_regs[4] + d : m_regs[4] - d;
            if (stack_addr32) m_regs[4] = e;
            else m_regs[4] = (m_regs[4] & 32'hFFFF_0000) | (e & 32'h0000_FFFF);
        end
        if (legal) begin
            model_write(int'(write_index), write_size, write_data);
            m_busy[t] = 1'b0;
        end
        if (issue_enable) m_busy[issue_index] = 1'b1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle();
        write_enable  = 1'b0;
        write_index   = '0;
        write_size    = 2'b10;
        write_data    = '0;
        stack_enable  = 1'b0;
        stack_pop     = 1'b0;
        stack_op32    = 1'b1;
        stack_addr32  = 1'b1;
        issue_enable  = 1'b0;
        issue_index   = '0;
        read_index[0] = '0;
        read_index[1] = '0;
        read_size[0]  = 2'b10;
        read_size[1]  = 2'b10;
    endtask

    task automatic tick();
        if (reset) model_reset();
        else model_apply();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_write(int idx, logic [1:0] sz, logic [31:0] d);
        write_enable = 1'b1;
        write_index  = IW'(idx);
        write_size   = sz;
        write_data   = d;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        idle();
        tick();
        drive_write(1, 2'b10, 32'h1234_5678);
        issue_enable = 1'b1; issue_index = 3'd2;
        stack_enable = 1'b1;
        read_size[1] = 2'b11;
        tick();
        reset = 1'b0;
        idle();
        #1;
        tests_run++;
        if (regs_flat !== '0) begin
            tests_failed++;
            $display("FAIL reset_regs: got %h expected 0", regs_flat);
        end
        tests_run++;
        if (busy !== '0 || size_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: busy=%b size_error=%b expected 0/0", busy, size_error);
        end
        tests_run++;
        if (read_data[0] !== 32'h0 || read_busy[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_read: data=%h busy=%b expected 0/0", read_data[0], read_busy[0]);
        end
    endtask

    task automatic test_dword_read();
        idle();
        drive_write(1, 2'b10, 32'hDEAD_BEEF);
        tick();
        idle();
        read_index[0] = 3'd1; read_size[0] = 2'b10;
        read_index[1] = 3'd1; read_size[1] = 2'b01;
        #1;
        tests_run++;
        if (read_data[0] !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL ecx_dword: got %h expected deadbeef", read_data[0]);
        end
        tests_run++;
        if (read_data[1] !== 32'h0000_BEEF) begin
            tests_failed++;
            $display("FAIL ecx_word: got %h expected 0000beef", read_data[1]);
        end
    endtask

    task automatic test_byte_word_merge();
        idle();
        drive_write(0, 2'b10, 32'h1122_3344);
        tick();
        drive_write(4, 2'b00, 32'h0000_00AA);
        tick();
        idle();
        read_index[0] = 3'd0; read_size[0] = 2'b10;
        read_index[1] = 3'd4; read_size[1] = 2'b00;
        #1;
        tests_run++;
        if (read_data[0] !== 32'h1122_AA44) begin
            tests_failed++;
            $display("FAIL ah_merge: got %h expected 1122aa44", read_data[0]);
        end
        tests_run++;
        if (read_data[1] !== 32'h0000_00AA) begin
            tests_failed++;
            $display("FAIL ah_read: got %h expected 000000aa", read_data[1]);
        end
        drive_write(0, 2'b01, 32'hFFFF_5566);
        tick();
        idle();
        #1;
        tests_run++;
        if (read_data[0] !== 32'h1122_5566) begin
            tests_failed++;
            $display("FAIL ax_merge: got %h expected 11225566", read_data[0]);
        end
    endtask

    task automatic test_stack();
        idle();
        drive_write(4, 2'b10, 32'h0000_0002);
        tick();
        idle();
        stack_enable = 1'b1; stack_pop = 1'b0; stack_op32 = 1'b1; stack_addr32 = 1'b0;
        tick();
        tests_run++;
        if (regs_flat[4*32 +: 32] !== 32'h0000_FFFE) begin
            tests_failed++;
            $display("FAIL push_sp16: got %h expected 0000fffe", regs_flat[4*32 +: 32]);
        end
        idle();
        drive_write(4, 2'b10, 32'h0000_0002);
        tick();
        idle();
        stack_enable = 1'b1; stack_pop = 1'b0; stack_op32 = 1'b1; stack_addr32 = 1'b1;
        tick();
        tick();
        tests_run++;
        if (regs_flat[4*32 +: 32] !== 32'hFFFF_FFFA) begin
            tests_failed++;
            $display("FAIL push_esp32: got %h expected fffffffa", regs_flat[4*32 +: 32]);
        end
        idle();
        drive_write(4, 2'b10, 32'h1234_FFFF);
        tick();
        idle();
        stack_enable = 1'b1; stack_pop = 1'b1; stack_op32 = 1'b0; stack_addr32 = 1'b0;
        tick();
        idle();
        tests_run++;
        if (regs_flat[4*32 +: 32] !== 32'h1234_0001) begin
            tests_failed++;
            $display("FAIL pop_sp16_wrap: got %h expected 12340001", regs_flat[4*32 +: 32]);
        end
    endtask

    task automatic test_bypass();
        idle();
        drive_write(2, 2'b10, 32'h0F0F_0F0F);
        read_index[0] = 3'd2; read_size[0] = 2'b10;
        read_index[1] = 3'd6; read_size[1] = 2'b00;
        #1;
        tests_run++;
        if (read_data[0] !== 32'h0F0F_0F0F) begin
            tests_failed++;
            $display("FAIL bypass_dword: got %h expected 0f0f0f0f", read_data[0]);
        end
        tests_run++;
        if (read_data[1] !== 32'h0000_000F) begin
            tests_failed++;
            $display("FAIL bypass_dh: got %h expected 0000000f", read_data[1]);
        end
        tick();
        idle();
    endtask

    task automatic test_scoreboard();
        idle();
        issue_enable = 1'b1; issue_index = 3'd3;
        read_index[0] = 3'd3;
        #1;
        tests_run++;
        if (read_busy[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_same_cycle: got %b expected 0", read_busy[0]);
        end
        tick();
        idle();
        read_index[0] = 3'd3; read_size[0] = 2'b10;
        read_index[1] = 3'd7; read_size[1] = 2'b00;
        #1;
        tests_run++;
        if (read_busy !== 2'b11) begin
            tests_failed++;
            $display("FAIL busy_read: got %b expected 11", read_busy);
        end
        drive_write(3, 2'b10, 32'hCAFE_0003);
        tick();
        tests_run++;
        if (busy[3] !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_clear: got %b expected 0", busy[3]);
        end
        issue_enable = 1'b1; issue_index = 3'd3;
        tick();
        tests_run++;
        if (busy[3] !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_set_wins: got %b expected 1", busy[3]);
        end
        idle();
        drive_write(7, 2'b00, 32'h0000_0055);
        tick();
        idle();
        tests_run++;
        if (busy[3] !== 1'b0 || regs_flat[3*32 +: 32] !== 32'hCAFE_5503) begin
            tests_failed++;
            $display("FAIL bh_clear: busy=%b ebx=%h expected 0/cafe5503", busy[3], regs_flat[3*32 +: 32]);
        end
    endtask

    task automatic test_esp_conflict_and_illegal();
        logic [31:0] exp_eax;
        idle();
        drive_write(4, 2'b10, 32'h0000_0100);
        stack_enable = 1'b1; stack_pop = 1'b1;
        tick();
        tests_run++;
        if (regs_flat[4*32 +: 32] !== 32'h0000_0100) begin
            tests_failed++;
            $display("FAIL esp_write_wins: got %h expected 00000100", regs_flat[4*32 +: 32]);
        end
        idle();
        drive_write(4, 2'b00, 32'h0000_0077);
        stack_enable = 1'b1; stack_pop = 1'b0; stack_op32 = 1'b1; stack_addr32 = 1'b1;
        exp_eax = (m_regs[0] & 32'hFFFF_00FF) | 32'h0000_7700;
        tick();
        tests_run++;
        if (regs_flat[4*32 +: 32] !== 32'h0000_00FC || regs_flat[31:0] !== exp_eax) begin
            tests_failed++;
            $display("FAIL ah_plus_push: esp=%h eax=%h expected 000000fc/%h",
                     regs_flat[4*32 +: 32], regs_flat[31:0], exp_eax);
        end
        idle();
        drive_write(1, 2'b11, 32'hFFFF_FFFF);
        tick();
        idle();
        tests_run++;
        if (regs_flat[1*32 +: 32] !== 32'hDEAD_BEEF || size_error !== 1'b1) begin
            tests_failed++;
            $display("FAIL illegal_write: ecx=%h size_error=%b expected deadbeef/1",
                     regs_flat[1*32 +: 32], size_error);
        end
        read_index[1] = 3'd1; read_size[1] = 2'b11;
        #1;
        tests_run++;
        if (read_data[1] !== 32'h0) begin
            tests_failed++;
            $display("FAIL illegal_read: got %h expected 0", read_data[1]);
        end
        tick();
        idle();
        tests_run++;
        if (size_error !== 1'b1) begin
            tests_failed++;
            $display("FAIL illegal_read_flag: got %b expected 1", size_error);
        end
        tick();
        tests_run++;
        if (size_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL size_error_pulse: got %b expected 0", size_error);
        end
    endtask

    task automatic test_random();
        logic [1:0] sz;
        for (int n = 0; n < 400; n++) begin
            idle();
            write_enable = 1'($urandom_range(0, 1));
            write_index  = IW'($urandom_range(0, 7));
            write_size   = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            write_data   = $urandom;
            stack_enable = 1'($urandom_range(0, 1));
            stack_pop    = 1'($urandom_range(0, 1));
            stack_op32   = 1'($urandom_range(0, 1));
            stack_addr32 = 1'($urandom_range(0, 1));
            issue_enable = 1'($urandom_range(0, 1));
            issue_index  = IW'($urandom_range(0, 7));
            for (int p = 0; p < READ_PORTS; p++) begin
                read_index[p] = IW'($urandom_range(0, 7));
                read_size[p]  = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            end
            #1;
            for (int p = 0; p < READ_PORTS; p++) begin
                sz = read_size[p];
                tests_run++;
                if (read_data[p] !== fwd_read(int'(read_index[p]), sz)) begin
                    tests_failed++;
                    $display("FAIL rand_read[%0d] cycle %0d: got %h expected %h", p, n,
                             read_data[p], fwd_read(int'(read_index[p]), sz));
                end
                tests_run++;
                if (read_busy[p] !== m_busy[m_target(int'(read_index[p]), sz)]) begin
                    tests_failed++;
                    $display("FAIL rand_read_busy[%0d] cycle %0d: got %b expected %b", p, n,
                             read_busy[p], m_busy[m_target(int'(read_index[p]), sz)]);
                end
            end
            tick();
            for (int i = 0; i < REG_COUNT; i++) begin
                tests_run++;
                if (regs_flat[32*i +: 32] !== m_regs[i]) begin
                    tests_failed++;
                    $display("FAIL rand_reg[%0d] cycle %0d: got %h expected %h", i, n,
                             regs_flat[32*i +: 32], m_regs[i]);
                end
            end
            tests_run++;
            if (busy !== m_busy || size_error !== m_size_err) begin
                tests_failed++;
                $display("FAIL rand_flags cycle %0d: busy=%b size_error=%b expected %b/%b", n,
                         busy, size_error, m_busy, m_size_err);
            end
        end
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        @(posedge clock);
        #1;
        test_reset();
        test_dword_read();
        test_byte_word_merge();
        test_stack();
        test_bypass();
        test_scoreboard();
        test_esp_conflict_and_illegal();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
